// File: rtl/branch_commit_queue.sv
// rtl/branch_commit_queue.sv - in-order branch commit queue with flush on mispredict (optional stats: BRQ_STATS_EN)
module branch_commit_queue #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int PC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [11:0]       alloc_opcode,
  input  logic              alloc_predicted,
  input  logic [PC_W-1:0]   alloc_target_pc,
  input  logic [PC_W-1:0]   alloc_fallthrough_pc,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_tag,
  input  logic              resolve_valid,
  input  logic [IDX_W-1:0]  resolve_tag,
  input  logic              resolve_taken,
  output logic [11:0]       Commit_opcode,
  output logic              Wrong_prediction,
  output logic              commit_valid,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [IDX_W:0]    count,
  output logic [15:0]       stat_commits,
  output logic [15:0]       stat_mispredicts
);

  // Conditional-branch encodings: {funct3, 2'b00, major opcode 7'b1100011}
  localparam logic [11:0]      OP_BEQ     = 12'h063;
  localparam logic [11:0]      OP_BNE     = 12'h263;
  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE    = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);

  // Entry state: control bits are reset, payload is only meaningful while valid
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic [DEPTH-1:0] predicted_q;
  logic [DEPTH-1:0] taken_q;
  logic [11:0]      opcode_q   [DEPTH];
  logic [PC_W-1:0]  target_q   [DEPTH];
  logic [PC_W-1:0]  fallthru_q [DEPTH];

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   count_q;

  logic             is_branch;
  logic             alloc_fire;
  logic             resolve_fire;
  logic             retire;
  logic             mispredict;
  logic [PC_W-1:0]  head_redirect;

  // Handshake and event decode, all from registered state plus current inputs
  always_comb begin
    is_branch     = (alloc_opcode == OP_BEQ) || (alloc_opcode == OP_BNE);
    alloc_ready   = (count_q < FULL_COUNT) && !flush;
    alloc_fire    = alloc_valid && alloc_ready && is_branch;
    resolve_fire  = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
    retire        = valid_q[head_q] && resolved_q[head_q];
    mispredict    = retire && (predicted_q[head_q] != taken_q[head_q]);
    head_redirect = taken_q[head_q] ? target_q[head_q] : fallthru_q[head_q];
  end

  assign alloc_tag = tail_q;
  assign count     = count_q;

  // Pointers, occupancy and per-entry valid/resolved; a mispredict wipes everything younger
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else if (mispredict) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      if (alloc_fire) begin
        valid_q[tail_q]    <= 1'b1;
        resolved_q[tail_q] <= 1'b0;
        tail_q             <= tail_q + PTR_ONE;
      end
      if (resolve_fire) begin
        resolved_q[resolve_tag] <= 1'b1;
      end
      if (retire) begin
        valid_q[head_q]    <= 1'b0;
        resolved_q[head_q] <= 1'b0;
        head_q             <= head_q + PTR_ONE;
      end
      case ({alloc_fire, retire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload capture; stale contents of invalid slots are never observed
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      opcode_q[tail_q]    <= alloc_opcode;
      predicted_q[tail_q] <= alloc_predicted;
      target_q[tail_q]    <= alloc_target_pc;
      fallthru_q[tail_q]  <= alloc_fallthrough_pc;
    end
    if (resolve_fire) begin
      taken_q[resolve_tag] <= resolve_taken;
    end
  end

  // Registered retirement feedback: single-cycle pulses toward predictor and fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid     <= 1'b0;
      Commit_opcode    <= '0;
      Wrong_prediction <= 1'b0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      commit_valid     <= retire;
      Commit_opcode    <= retire ? opcode_q[head_q] : 12'b0;
      Wrong_prediction <= mispredict;
      flush            <= mispredict;
      redirect_pc      <= mispredict ? head_redirect : '0;
    end
  end

`ifdef BRQ_STATS_EN
  // Saturating event counters; survive flushes, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (retire && (stat_commits != 16'hFFFF)) begin
        stat_commits <= stat_commits + 16'd1;
      end
      if (mispredict && (stat_mispredicts != 16'hFFFF)) begin
        stat_mispredicts <= stat_mispredicts + 16'd1;
      end
    end
  end
`else
  assign stat_commits     = 16'b0;
  assign stat_mispredicts = 16'b0;
`endif

endmodule

// File: tb/tb_branch_commit_queue.sv
// tb/tb_branch_commit_queue.sv - directed self-checking bench for branch_commit_queue
module tb_branch_commit_queue;

  localparam logic [11:0] OP_BEQ = 12'h063;
  localparam logic [11:0] OP_BNE = 12'h263;
  localparam logic [11:0] OP_ADD = 12'h033;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [11:0] alloc_opcode;
  logic        alloc_predicted;
  logic [31:0] alloc_target_pc;
  logic [31:0] alloc_fallthrough_pc;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        resolve_valid;
  logic [2:0]  resolve_tag;
  logic        resolve_taken;
  logic [11:0] Commit_opcode;
  logic        Wrong_prediction;
  logic        commit_valid;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic [15:0] stat_commits;
  logic [15:0] stat_mispredicts;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_commit_queue #(.DEPTH(8), .IDX_W(3), .PC_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .alloc_valid          (alloc_valid),
    .alloc_opcode         (alloc_opcode),
    .alloc_predicted      (alloc_predicted),
    .alloc_target_pc      (alloc_target_pc),
    .alloc_fallthrough_pc (alloc_fallthrough_pc),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .resolve_valid        (resolve_valid),
    .resolve_tag          (resolve_tag),
    .resolve_taken        (resolve_taken),
    .Commit_opcode        (Commit_opcode),
    .Wrong_prediction     (Wrong_prediction),
    .commit_valid         (commit_valid),
    .flush                (flush),
    .redirect_pc          (redirect_pc),
    .count                (count),
    .stat_commits         (stat_commits),
    .stat_mispredicts     (stat_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic set_alloc(input logic [11:0] op, input logic pred,
                           input logic [31:0] tgt, input logic [31:0] ft);
    alloc_valid          = 1'b1;
    alloc_opcode         = op;
    alloc_predicted      = pred;
    alloc_target_pc      = tgt;
    alloc_fallthrough_pc = ft;
  endtask

  task automatic set_resolve(input logic [2:0] tag, input logic taken);
    resolve_valid = 1'b1;
    resolve_tag   = tag;
    resolve_taken = taken;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_opcode = '0; alloc_predicted = 1'b0;
    alloc_target_pc = '0; alloc_fallthrough_pc = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0;

    // Reset held two cycles with an alloc attempt present
    set_alloc(OP_BEQ, 1'b1, 32'h40, 32'h44);
    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_commit_valid", 32'(commit_valid), 0);
    check("rst_commit_opcode", 32'(Commit_opcode), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_redirect", redirect_pc, 0);
    rst = 1'b0;
    clear_inputs();
    step();
    check("rst_count_after", 32'(count), 0);

    // In-order, correctly predicted pair
    check("io_tag0", 32'(alloc_tag), 0);
    set_alloc(OP_BEQ, 1'b1, 32'h100, 32'h104); step(); clear_inputs();
    check("io_tag1", 32'(alloc_tag), 1);
    set_alloc(OP_BNE, 1'b0, 32'h200, 32'h204); step(); clear_inputs();
    check("io_count2", 32'(count), 2);
    set_resolve(3'd0, 1'b1); step(); clear_inputs();
    check("io_no_commit_yet", 32'(commit_valid), 0);
    set_resolve(3'd1, 1'b0); step(); clear_inputs();
    check("io_c0_valid", 32'(commit_valid), 1);
    check("io_c0_opcode", 32'(Commit_opcode), 32'(OP_BEQ));
    check("io_c0_wrong", 32'(Wrong_prediction), 0);
    check("io_c0_flush", 32'(flush), 0);
    step();
    check("io_c1_valid", 32'(commit_valid), 1);
    check("io_c1_opcode", 32'(Commit_opcode), 32'(OP_BNE));
    check("io_c1_wrong", 32'(Wrong_prediction), 0);
    check("io_count0", 32'(count), 0);
    step();
    check("io_pulse_end", 32'(commit_valid), 0);
    check("io_opcode_zero", 32'(Commit_opcode), 0);

    // Out-of-order resolution: tags 2,3,4 resolved youngest first
    check("ooo_tag2", 32'(alloc_tag), 2);
    set_alloc(OP_BEQ, 1'b0, 32'h300, 32'h304); step(); clear_inputs();
    set_alloc(OP_BNE, 1'b1, 32'h310, 32'h314); step(); clear_inputs();
    set_alloc(OP_BEQ, 1'b0, 32'h320, 32'h324); step(); clear_inputs();
    check("ooo_count3", 32'(count), 3);
    set_resolve(3'd4, 1'b0); step(); clear_inputs();
    check("ooo_wait_a", 32'(commit_valid), 0);
    set_resolve(3'd3, 1'b1); step(); clear_inputs();
    check("ooo_wait_b", 32'(commit_valid), 0);
    set_resolve(3'd2, 1'b0); step(); clear_inputs();
    check("ooo_wait_c", 32'(commit_valid), 0);
    step();
    check("ooo_c2_valid", 32'(commit_valid), 1);
    check("ooo_c2_opcode", 32'(Commit_opcode), 32'(OP_BEQ));
    step();
    check("ooo_c3_valid", 32'(commit_valid), 1);
    check("ooo_c3_opcode", 32'(Commit_opcode), 32'(OP_BNE));
    check("ooo_c3_wrong", 32'(Wrong_prediction), 0);
    step();
    check("ooo_c4_valid", 32'(commit_valid), 1);
    check("ooo_c4_opcode", 32'(Commit_opcode), 32'(OP_BEQ));
    check("ooo_count0", 32'(count), 0);

    // Mispredict flush from a fresh reset so tags start at 0
    rst = 1'b1; step(); rst = 1'b0;
    check("mp_tag0", 32'(alloc_tag), 0);
    set_alloc(OP_BEQ, 1'b0, 32'h200, 32'h100); step(); clear_inputs();
    set_alloc(OP_BNE, 1'b0, 32'h400, 32'h404); step(); clear_inputs();
    set_alloc(OP_BEQ, 1'b0, 32'h500, 32'h504); step(); clear_inputs();
    set_resolve(3'd1, 1'b0); step(); clear_inputs();
    set_resolve(3'd0, 1'b1); step(); clear_inputs();
    check("mp_no_commit_yet", 32'(commit_valid), 0);
    set_alloc(OP_BNE, 1'b0, 32'h600, 32'h604); step(); clear_inputs();
    check("mp_commit_valid", 32'(commit_valid), 1);
    check("mp_wrong", 32'(Wrong_prediction), 1);
    check("mp_flush", 32'(flush), 1);
    check("mp_redirect", redirect_pc, 32'h200);
    check("mp_count", 32'(count), 0);
    check("mp_ready_low", 32'(alloc_ready), 0);
    step();
    check("mp_flush_end", 32'(flush), 0);
    check("mp_redirect_zero", redirect_pc, 0);
    check("mp_no_younger_commit", 32'(commit_valid), 0);
    check("mp_ready_back", 32'(alloc_ready), 1);
    check("mp_alloc_dropped", 32'(count), 0);
    check("mp_tag_reset", 32'(alloc_tag), 0);
    step();
    check("mp_still_quiet", 32'(commit_valid), 0);
`ifdef BRQ_STATS_EN
    check("stat_mispredicts", 32'(stat_mispredicts), 1);
    check("stat_commits", 32'(stat_commits), 1);
`else
    check("stat_mispredicts_tied", 32'(stat_mispredicts), 0);
    check("stat_commits_tied", 32'(stat_commits), 0);
`endif

    // Fill to DEPTH, reject the ninth, retire one and wrap tag 0
    for (int i = 0; i < 8; i++) begin
      check("full_tag", 32'(alloc_tag), 32'(i));
      set_alloc(OP_BEQ, 1'b0, 32'h1000 + 32'(i), 32'h2000 + 32'(i)); step(); clear_inputs();
    end
    check("full_count", 32'(count), 8);
    check("full_ready", 32'(alloc_ready), 0);
    set_alloc(OP_BNE, 1'b0, 32'h3000, 32'h3004); step(); clear_inputs();
    check("full_ninth_ignored", 32'(count), 8);
    set_resolve(3'd0, 1'b0); step(); clear_inputs();
    check("full_no_commit_yet", 32'(commit_valid), 0);
    step();
    check("full_c0_valid", 32'(commit_valid), 1);
    check("full_c0_opcode", 32'(Commit_opcode), 32'(OP_BEQ));
    check("full_count7", 32'(count), 7);
    check("full_ready_again", 32'(alloc_ready), 1);
    check("wrap_tag0", 32'(alloc_tag), 0);
    set_alloc(OP_BNE, 1'b1, 32'h5000, 32'h5004); step(); clear_inputs();
    check("wrap_count8", 32'(count), 8);
    check("wrap_ready_low", 32'(alloc_ready), 0);
    set_resolve(3'd0, 1'b1); step(); clear_inputs();
    check("wrap_tag0_waits", 32'(commit_valid), 0);
    for (int k = 1; k < 8; k++) begin
      set_resolve(3'(k), 1'b0); step(); clear_inputs();
      if (k == 1) begin
        check("wrap_first_wait", 32'(commit_valid), 0);
      end else begin
        check("wrap_old_valid", 32'(commit_valid), 1);
        check("wrap_old_opcode", 32'(Commit_opcode), 32'(OP_BEQ));
      end
    end
    step();
    check("wrap_tag7_valid", 32'(commit_valid), 1);
    check("wrap_tag7_opcode", 32'(Commit_opcode), 32'(OP_BEQ));
    step();
    check("wrap_new0_valid", 32'(commit_valid), 1);
    check("wrap_new0_opcode", 32'(Commit_opcode), 32'(OP_BNE));
    check("wrap_new0_wrong", 32'(Wrong_prediction), 0);
    check("wrap_new0_flush", 32'(flush), 0);
    step();
    check("wrap_empty", 32'(count), 0);
    check("wrap_quiet", 32'(commit_valid), 0);

    // Non-branch opcode and stray resolve
    set_alloc(OP_ADD, 1'b0, 32'h7000, 32'h7004); step(); clear_inputs();
    check("nb_count", 32'(count), 0);
    set_resolve(3'd3, 1'b1); step(); clear_inputs();
    step();
    check("stray_no_commit", 32'(commit_valid), 0);
    check("stray_no_flush", 32'(flush), 0);
    check("stray_count", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
